// File: rtl/instr_encoder.sv
// LEGv8 instruction encoder: packs decoded fields into 32-bit machine words and
// queues them in a 2-entry valid/ready FIFO tagged with a running word address.
module instr_encoder #(
   parameter int AW   = 8,
   parameter int ERRW = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      op_class,
   input  logic [1:0]      alu_sel,
   input  logic            set_flags,
   input  logic [4:0]      rd,
   input  logic [4:0]      rn,
   input  logic [4:0]      rm,
   input  logic [18:0]     imm,
   input  logic [3:0]      cond,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     instr,
   output logic [AW-1:0]   addr,
   output logic            err,
   output logic [ERRW-1:0] err_count
);

   localparam logic [AW-1:0]   ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [ERRW-1:0] ERR_ONE  = {{(ERRW-1){1'b0}}, 1'b1};
   localparam logic [ERRW-1:0] ERR_MAX  = {ERRW{1'b1}};

   // Returns {legal, word}; the word is meaningless when legal is clear.
   function automatic logic [32:0] encode_word(
      input logic [2:0]  cls,
      input logic [1:0]  sel,
      input logic        sf,
      input logic [4:0]  f_rd,
      input logic [4:0]  f_rn,
      input logic [4:0]  f_rm,
      input logic [18:0] f_imm,
      input logic [3:0]  f_cond
   );
      logic        ok;
      logic [31:0] word;
      logic [10:0] opc_r;
      logic [9:0]  opc_i;
      ok    = 1'b1;
      word  = 32'h0000_0000;
      opc_r = 11'b000_0000_0000;
      opc_i = 10'b00_0000_0000;
      case (cls)
         3'd0: begin
            case ({sf, sel})
               3'b000:  opc_r = 11'b10001011000;
               3'b001:  opc_r = 11'b11001011000;
               3'b010:  opc_r = 11'b10001010000;
               3'b011:  opc_r = 11'b10101010000;
               3'b100:  opc_r = 11'b10101011000;
               3'b101:  opc_r = 11'b11101011000;
               default: ok    = 1'b0;
            endcase
            word = {opc_r, f_rm, 6'b000000, f_rn, f_rd};
         end
         3'd1: begin
            case ({sf, sel})
               3'b000:  opc_i = 10'b1001000100;
               3'b001:  opc_i = 10'b1101000100;
               3'b100:  opc_i = 10'b1011000100;
               3'b101:  opc_i = 10'b1111000100;
               default: ok    = 1'b0;
            endcase
            word = {opc_i, f_imm[11:0], f_rn, f_rd};
         end
         3'd2:    word = {11'b11111000010, f_imm[8:0], 2'b00, f_rn, f_rd};
         3'd3:    word = {11'b11111000000, f_imm[8:0], 2'b00, f_rn, f_rd};
         3'd4:    word = {8'b10110100, f_imm, f_rd};
         3'd5:    word = {8'b01010100, f_imm, 1'b0, f_cond};
         default: ok   = 1'b0;
      endcase
      return {ok, word};
   endfunction

   logic [31:0] mem_r [2];
   logic        wr_ptr_r;
   logic        rd_ptr_r;
   logic [1:0]  count_r;
   logic [1:0]  count_nxt_s;
   logic [AW-1:0]   addr_r;
   logic            err_r;
   logic [ERRW-1:0] err_count_r;

   logic [32:0] enc_s;
   logic        legal_s;
   logic [31:0] word_s;
   logic        accept_s;
   logic        push_s;
   logic        pop_s;
   logic        illegal_s;

   assign enc_s     = encode_word(op_class, alu_sel, set_flags, rd, rn, rm, imm, cond);
   assign legal_s   = enc_s[32];
   assign word_s    = enc_s[31:0];

   // in_ready is purely occupancy based, so a full FIFO never passes a word through.
   assign in_ready  = (count_r != 2'd2);
   assign out_valid = (count_r != 2'd0);
   assign accept_s  = in_valid && in_ready;
   assign push_s    = accept_s && legal_s;
   assign illegal_s = accept_s && !legal_s;
   assign pop_s     = out_valid && out_ready;

   assign instr     = mem_r[rd_ptr_r];
   assign addr      = addr_r;
   assign err       = err_r;
   assign err_count = err_count_r;

   // Next FIFO occupancy from push/pop combination.
   always_comb begin
      count_nxt_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_nxt_s = count_r + 2'd1;
         2'b01:   count_nxt_s = count_r - 2'd1;
         default: count_nxt_s = count_r;
      endcase
   end

   // FIFO storage, pointers and occupancy.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_r[0] <= 32'h0000_0000;
         mem_r[1] <= 32'h0000_0000;
         wr_ptr_r <= 1'b0;
         rd_ptr_r <= 1'b0;
         count_r  <= 2'd0;
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= word_s;
            wr_ptr_r        <= ~wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= ~rd_ptr_r;
         end
         count_r <= count_nxt_s;
      end
   end

   // Head word address advances with each pop and wraps naturally.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_r <= {AW{1'b0}};
      end else if (pop_s) begin
         addr_r <= addr_r + ADDR_ONE;
      end else begin
         addr_r <= addr_r;
      end
   end

   // Dropped-request pulse and saturating counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_r       <= 1'b0;
         err_count_r <= {ERRW{1'b0}};
      end else begin
         err_r <= illegal_s;
         if (illegal_s && (err_count_r != ERR_MAX)) begin
            err_count_r <= err_count_r + ERR_ONE;
         end else begin
            err_count_r <= err_count_r;
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed steps plus random traffic
// checked against a queue-based reference model.
module tb_instr_encoder;
   localparam int AW   = 8;
   localparam int ERRW = 4;
   localparam int ERR_SAT = (1 << ERRW) - 1;

   logic            clk = 1'b0;
   logic            reset;
   logic            in_valid;
   logic            in_ready;
   logic [2:0]      op_class;
   logic [1:0]      alu_sel;
   logic            set_flags;
   logic [4:0]      rd, rn, rm;
   logic [18:0]     imm;
   logic [3:0]      cond;
   logic            out_valid;
   logic            out_ready;
   logic [31:0]     instr;
   logic [AW-1:0]   addr;
   logic            err;
   logic [ERRW-1:0] err_count;

   instr_encoder #(.AW(AW), .ERRW(ERRW)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .op_class(op_class), .alu_sel(alu_sel), .set_flags(set_flags),
      .rd(rd), .rn(rn), .rm(rm), .imm(imm), .cond(cond),
      .out_valid(out_valid), .out_ready(out_ready), .instr(instr),
      .addr(addr), .err(err), .err_count(err_count)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_q [$];
   int          m_addr   = 0;
   int          m_errcnt = 0;
   bit          m_err    = 1'b0;
   bit          last_acc = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference encoder built from opcode values with plain arithmetic.
   function automatic void ref_encode(input int cls, input int sel, input int sf,
                                      input int f_rd, input int f_rn, input int f_rm,
                                      input int f_imm, input int f_cond,
                                      output bit legal, output logic [31:0] w);
      longint v;
      longint base;
      legal = 1'b1;
      v = 0;
      case (cls)
         0: begin
            if (sf != 0 && sel >= 2) legal = 1'b0;
            base = (sel == 0) ? 64'h458 : (sel == 1) ? 64'h658 : (sel == 2) ? 64'h450 : 64'h550;
            if (sf != 0) base = base + 64'h100;
            v = base * (2**21) + f_rm * (2**16) + f_rn * 32 + f_rd;
         end
         1: begin
            if (sel >= 2) legal = 1'b0;
            base = 64'h244 + sel * 64'h100 + sf * 64'h80;
            v = base * (2**22) + (f_imm % 4096) * 1024 + f_rn * 32 + f_rd;
         end
         2, 3: begin
            base = (cls == 2) ? 64'h7C2 : 64'h7C0;
            v = base * (2**21) + (f_imm % 512) * 4096 + f_rn * 32 + f_rd;
         end
         4: v = 64'hB4 * (2**24) + f_imm * 32 + f_rd;
         5: v = 64'h54 * (2**24) + f_imm * 32 + f_cond;
         default: legal = 1'b0;
      endcase
      w = v[31:0];
   endfunction

   task automatic set_req(input int cls, input int sel, input int sf, input int r_d,
                          input int r_n, input int r_m, input int im, input int cd);
      op_class  = 3'(cls);
      alu_sel   = 2'(sel);
      set_flags = 1'(sf);
      rd        = 5'(r_d);
      rn        = 5'(r_n);
      rm        = 5'(r_m);
      imm       = 19'(im);
      cond      = 4'(cd);
   endtask

   task automatic rand_req(input int lo_cls, input int hi_cls);
      set_req($urandom_range(hi_cls, lo_cls), $urandom_range(3, 0), $urandom_range(1, 0),
              $urandom_range(31, 0), $urandom_range(31, 0), $urandom_range(31, 0),
              $urandom_range(19'h7FFFF, 0), $urandom_range(15, 0));
   endtask

   // One clock: predict from the model, advance, then compare every output.
   task automatic tick();
      bit          acc, pop, legal;
      logic [31:0] w;
      acc = in_valid && (exp_q.size() < 2);
      pop = (exp_q.size() > 0) && out_ready;
      ref_encode(int'(op_class), int'(alu_sel), int'(set_flags), int'(rd), int'(rn),
                 int'(rm), int'(imm), int'(cond), legal, w);
      @(posedge clk);
      #1;
      if (pop) begin
         void'(exp_q.pop_front());
         m_addr = (m_addr + 1) % (1 << AW);
      end
      if (acc && legal) exp_q.push_back(w);
      m_err = acc && !legal;
      if (m_err && m_errcnt < ERR_SAT) m_errcnt++;
      last_acc = acc;
      check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
      check("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
      if (exp_q.size() > 0) check("instr", instr, exp_q[0]);
      check("addr", 32'(addr), 32'(m_addr));
      check("err", 32'(err), 32'(m_err));
      check("err_count", 32'(err_count), 32'(m_errcnt));
   endtask

   logic [31:0] kw [5];

   initial begin
      reset     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      set_req(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_instr", instr, 32'h0);
      check("rst_addr", 32'(addr), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_err_count", 32'(err_count), 32'd0);
      reset = 1'b1;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // ADDS rd=3 rn=1 rm=2, visible one cycle later at addr 0
      set_req(0, 0, 1, 3, 1, 2, 0, 0);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check("adds_word", instr, 32'hAB020023);
      check("adds_addr", 32'(addr), 32'd0);
      tick();
      check("adds_addr_next", 32'(addr), 32'd1);

      // Directed encodings, streamed back-to-back
      kw[0] = 32'hF8408045; kw[1] = 32'hF81FF087; kw[2] = 32'hB4FFFFE9;
      kw[3] = 32'h5400008B; kw[4] = 32'hF13FFC21;
      for (int i = 0; i < 5; i++) begin
         case (i)
            0: set_req(2, 0, 0, 5, 2, 0, 8, 0);
            1: set_req(3, 0, 0, 7, 4, 0, 19'h1FF, 0);
            2: set_req(4, 0, 0, 9, 0, 0, 19'h7FFFF, 0);
            3: set_req(5, 0, 0, 0, 0, 0, 4, 4'hB);
            default: set_req(1, 1, 1, 1, 1, 0, 12'hFFF, 0);
         endcase
         in_valid = 1'b1;
         tick();
         check($sformatf("enc_word%0d", i), instr, kw[i]);
      end
      in_valid = 1'b0;
      tick();

      // Backpressure: two accepts fill the FIFO, third waits for a pop
      out_ready = 1'b0;
      in_valid  = 1'b1;
      set_req(0, 1, 0, 10, 11, 12, 0, 0);
      tick();
      set_req(1, 0, 0, 13, 14, 0, 77, 0);
      tick();
      check("full_in_ready", 32'(in_ready), 32'd0);
      set_req(4, 0, 0, 15, 0, 0, 1234, 0);
      tick();
      tick();
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (last_acc) break;
      end
      in_valid = 1'b0;
      repeat (3) tick();

      // Illegal requests: class 7 then ORR with flags
      in_valid = 1'b1;
      set_req(7, 0, 0, 1, 1, 1, 0, 0);
      tick();
      set_req(0, 3, 1, 1, 1, 1, 0, 0);
      tick();
      in_valid = 1'b0;
      tick();
      check("illegal_count2", 32'(err_count), 32'd2);
      in_valid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         if (k % 2 == 0) set_req(6, 0, 0, 0, 0, 0, 0, 0);
         else set_req(1, 2 + (k % 4) / 2, k % 3 == 0 ? 1 : 0, 0, 0, 0, 0, 0);
         tick();
      end
      in_valid = 1'b0;
      tick();
      check("err_saturated", 32'(err_count), 32'd15);

      // Sustained stream: more than 2^AW pops forces the address to wrap
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 262; k++) begin
         rand_req(2, 5);
         tick();
      end
      in_valid = 1'b0;
      tick();

      // Random traffic including illegal classes and backpressure
      for (int k = 0; k < 400; k++) begin
         rand_req(0, 7);
         in_valid  = 1'($urandom_range(1, 0));
         out_ready = 1'($urandom_range(3, 0) != 0);
         tick();
      end

      // Asynchronous reset with two words queued
      out_ready = 1'b0;
      in_valid  = 1'b1;
      rand_req(2, 5);
      while (exp_q.size() < 2) tick();
      in_valid = 1'b0;
      if (m_addr == 0) begin
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
         in_valid  = 1'b1;
         tick();
         in_valid = 1'b0;
      end
      check("pre_rst_valid", 32'(out_valid), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check("async_rst_valid", 32'(out_valid), 32'd0);
      check("async_rst_addr", 32'(addr), 32'd0);
      check("async_rst_err_count", 32'(err_count), 32'd0);
      exp_q.delete();
      m_addr   = 0;
      m_errcnt = 0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      set_req(0, 0, 0, 3, 1, 2, 0, 0);
      tick();
      in_valid = 1'b0;
      check("post_rst_addr", 32'(addr), 32'd0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
